rename_recovery_ctrl: RTL and testbench
=======================================

# rename_recovery_ctrl

Sequences rename-state recovery after a pipeline flush, and arbitrates the free-list push port between commit-side frees and the recovery walk. On a flush raised at retirement, it freezes the front end. It then walks the squashed ROB range youngest-to-oldest, returning every allocated physical destination register to the free list. Finally it issues a single rename-RAT overwrite from the retirement RAT and releases the pipeline. It sits between the ROB/commit logic and the rename stage's free list and RAT overwrite port.

## Interface
- PHYSREGS_DEPTH, 6, physical register index width
- ROB_ADDRWIDTH, 6, ROB index width
- RENRAT_WIDTH, PHYSREGS_DEPTH, RAT entry width
- RENRAT_DEPTH, 32, architectural registers

Ports:
- CLK  in  1  clock. This is the block's only clock.
- RESET  in  1  synchronous, active-high reset.
- fROB_flushReq_IN  in  1  one-cycle flush request. It is raised only when the faulting instruction retires.
- fROB_flushHead_IN  in  ROB_ADDRWIDTH  oldest squashed entry (inclusive).
- fROB_curTail_IN  in  ROB_ADDRWIDTH  ROB tail (next free slot).
- fROB_full_IN  in  1  ROB full flag, sampled with flushReq.
- tROB_probeIdx_OUT  out  ROB_ADDRWIDTH  entry being read.
- fROB_probeDestReqd_IN  in  1  probed entry allocated a dest reg (combinational response).
- fROB_probePhysDest_IN  in  PHYSREGS_DEPTH  probed entry's new phys dest.
- fCommit_freeReq_IN  in  1  commit frees a previous mapping.
- fCommit_freeData_IN  in  PHYSREGS_DEPTH  reg freed by commit.
- fFreeL_full_IN  in  1  free-list full.
- tFreeL_pushReq_OUT  out  1  free-list push (registered).
- tFreeL_pushData_OUT  out  PHYSREGS_DEPTH  pushed reg (registered).
- fRRAT_data_IN  in  RENRAT_WIDTH*RENRAT_DEPTH  retirement RAT, entry i at bits [i*W+W-1 : i*W].
- tRenRatOverwrite_OUT  out  1  RAT overwrite strobe.
- tRenRatOverwriteData_OUT  out  RENRAT_WIDTH*RENRAT_DEPTH  snapshot to load.
- tFrontEnd_freeze_OUT  out  1  stalls fetch/decode/rename.
- tROB_flushDone_OUT  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WALK, OVERWRITE, DONE.

IDLE
- On fROB_flushReq_IN, latch ptr = curTail-1 and end = flushHead (mod 2^ROB_ADDRWIDTH).
- Latch count = (curTail - flushHead) mod 2^ROB_ADDRWIDTH. If curTail == flushHead and fROB_full_IN = 1, count = 2^ROB_ADDRWIDTH.
- If count == 0, go to OVERWRITE. Otherwise go to WALK.
- fROB_flushReq_IN is ignored in every non-IDLE state.

WALK
- tROB_probeIdx_OUT = ptr.
- A walk step occurs in a cycle only when fCommit_freeReq_IN = 0 and fFreeL_full_IN = 0.
- On a step with fROB_probeDestReqd_IN = 1, push fROB_probePhysDest_IN.
- On every step, decrement ptr and count, with wrap from 0 to 2^W-1.
- On the step where count reaches 0, go to OVERWRITE.
- Stall cycles hold ptr and count and push nothing from the walk.

Arbitration
- fCommit_freeReq_IN has absolute priority, in every state including IDLE.
- The push port carries the commit free that cycle.
- The commit free ignores fFreeL_full_IN; it cannot overflow by construction.

OVERWRITE
- Lasts exactly one cycle.
- Asserts the overwrite strobe with the snapshot captured from fRRAT_data_IN on entry. Then go to DONE.

DONE
- Lasts one cycle.
- Asserts tROB_flushDone_OUT. Then go to IDLE.

Freeze
- tFrontEnd_freeze_OUT = (state != IDLE). It is decoded from the state register, with no combinational path from inputs.

## Timing
- Reset values: state IDLE and all outputs 0, including data buses, tROB_probeIdx_OUT, and ptr/count.
- Reset in any state aborts recovery immediately. Any pending push is dropped.
- flushReq sampled at cycle 0 → freeze high from cycle 1.
- Probe at step cycle k → push visible at k+1. Commit-free push is also visible one cycle after its request.
- N squashed entries with no stalls:
  - WALK occupies cycles 1..N.
  - Overwrite strobe at N+1.
  - flushDone at N+2.
  - Freeze low at N+3.
- Each stall cycle extends the schedule by one.
- count == 0: overwrite at 1, done at 2.
- tRenRatOverwriteData_OUT is held stable after the strobe until the next capture.
- The overwrite strobe and flushDone are never high in the same cycle.

## Test plan
- Basic walk:
  - Stimulus: head=4, tail=7, probes 6/5/4 return destReqd 1/0/1 with pregs 40/–/33.
  - Response: pushes 40 at cycle 2 and 33 at cycle 4, overwrite at 4, done at 5, freeze cycles 1–5.
- Wrap-around:
  - Stimulus: head=62, tail=1 (W=6).
  - Response: probe order 0, 63, 62; 3 steps.
- Full ROB:
  - Stimulus: head=tail=10, full=1.
  - Response: 64 probes, from 9 down through 10.
  - Stimulus: head=tail=10, full=0.
  - Response: no probes, overwrite at cycle 1.
- Contention:
  - Stimulus: commit free of preg 12 during the second WALK cycle; freelist full for 2 cycles later in the walk.
  - Response: 12 pushed that slot, ptr held; walk stalls 2 cycles; done delayed 3 cycles total.
- Snapshot:
  - Stimulus: RRAT entry 5 = 0x2A at OVERWRITE entry.
  - Response: data bits [35:30] = 0x2A during the strobe. A second flushReq during WALK is ignored.
- Reset mid-WALK:
  - Stimulus: RESET asserted during WALK.
  - Response: next cycle all outputs 0, state IDLE. A fresh flush afterward completes normally.

Source files
------------

// File: rtl/rename_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// rename_recovery_ctrl
//
// Purpose:
//   Restores rename state after a flush raised at retirement. The sequence is:
//   freeze the front end, walk the squashed ROB range from youngest to oldest
//   returning every allocated physical destination to the free list, load the
//   rename RAT from the retirement RAT snapshot, then release the pipeline.
//   The block also arbitrates the free-list push port. Commit-side frees always
//   win the port, and recovery-walk frees use it only when it is idle.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   fROB_flushReq_IN            one-cycle flush request (honoured in IDLE only)
//   fROB_flushHead_IN           oldest squashed ROB entry (inclusive)
//   fROB_curTail_IN             ROB tail (next free slot)
//   fROB_full_IN                ROB full flag, qualifies head == tail
//   tROB_probeIdx_OUT           ROB entry being probed during the walk
//   fROB_probeDestReqd_IN       probed entry allocated a destination
//   fROB_probePhysDest_IN       probed entry's physical destination
//   fCommit_freeReq_IN          commit frees a previous mapping
//   fCommit_freeData_IN         physical register freed by commit
//   fFreeL_full_IN              free list full (stalls walk frees only)
//   tFreeL_pushReq_OUT          registered free-list push strobe
//   tFreeL_pushData_OUT         registered free-list push data
//   fRRAT_data_IN               retirement RAT, entry i at [i*W +: W]
//   tRenRatOverwrite_OUT        rename RAT overwrite strobe
//   tRenRatOverwriteData_OUT    snapshot to load, held until the next capture
//   tFrontEnd_freeze_OUT        stalls fetch/decode/rename while recovering
//   tROB_flushDone_OUT          one-cycle recovery-complete pulse
// -----------------------------------------------------------------------------
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | waiting for a flush; only commit frees use the push port
// S_WALK      | probing squashed entries youngest->oldest, freeing their dests
// S_OVERWRITE | one-cycle rename RAT load from the captured RRAT snapshot
// S_DONE      | one-cycle completion pulse, then back to S_IDLE
//
module rename_recovery_ctrl #(
    parameter int PHYSREGS_DEPTH = 6,
    parameter int ROB_ADDRWIDTH  = 6,
    parameter int RENRAT_WIDTH   = PHYSREGS_DEPTH,
    parameter int RENRAT_DEPTH   = 32
) (
    input  logic                                 CLK,
    input  logic                                 RESET,

    input  logic                                 fROB_flushReq_IN,
    input  logic [ROB_ADDRWIDTH-1:0]             fROB_flushHead_IN,
    input  logic [ROB_ADDRWIDTH-1:0]             fROB_curTail_IN,
    input  logic                                 fROB_full_IN,

    output logic [ROB_ADDRWIDTH-1:0]             tROB_probeIdx_OUT,
    input  logic                                 fROB_probeDestReqd_IN,
    input  logic [PHYSREGS_DEPTH-1:0]            fROB_probePhysDest_IN,

    input  logic                                 fCommit_freeReq_IN,
    input  logic [PHYSREGS_DEPTH-1:0]            fCommit_freeData_IN,

    input  logic                                 fFreeL_full_IN,
    output logic                                 tFreeL_pushReq_OUT,
    output logic [PHYSREGS_DEPTH-1:0]            tFreeL_pushData_OUT,

    input  logic [RENRAT_WIDTH*RENRAT_DEPTH-1:0] fRRAT_data_IN,
    output logic                                 tRenRatOverwrite_OUT,
    output logic [RENRAT_WIDTH*RENRAT_DEPTH-1:0] tRenRatOverwriteData_OUT,

    output logic                                 tFrontEnd_freeze_OUT,
    output logic                                 tROB_flushDone_OUT
);

    // The count needs one extra bit so that a full ROB (2^ROB_ADDRWIDTH
    // squashed entries) can be represented.
    localparam int CNT_W = ROB_ADDRWIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ROB_ADDRWIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int SNAP_W = RENRAT_WIDTH * RENRAT_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WALK      = 2'd1,
        S_OVERWRITE = 2'd2,
        S_DONE      = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [ROB_ADDRWIDTH-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        push_q, push_d;
    logic [PHYSREGS_DEPTH-1:0]   push_data_q, push_data_d;
    logic [SNAP_W-1:0]           snap_q, snap_d;

    logic [ROB_ADDRWIDTH-1:0]    span;
    logic                        walk_step;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        snap_d      = snap_q;
        push_d      = 1'b0;
        push_data_d = '0;
        walk_step   = 1'b0;
        span        = fROB_curTail_IN - fROB_flushHead_IN;

        // A commit free owns the push port in every state. It never checks the
        // full flag because the free list cannot overflow on commit frees.
        if (fCommit_freeReq_IN) begin
            push_d      = 1'b1;
            push_data_d = fCommit_freeData_IN;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fROB_flushReq_IN) begin
                    ptr_d = fROB_curTail_IN - ROB_ADDRWIDTH'(1);
                    if (span == '0 && !fROB_full_IN) begin
                        // Nothing squashed: go straight to the RAT load.
                        count_d = '0;
                        snap_d  = fRRAT_data_IN;
                        state_d = S_OVERWRITE;
                    end else begin
                        // head == tail with full set covers the whole ROB.
                        count_d = (span == '0) ? CNT_FULL : {1'b0, span};
                        state_d = S_WALK;
                    end
                end
            end

            S_WALK: begin
                walk_step = !fCommit_freeReq_IN && !fFreeL_full_IN;
                if (walk_step) begin
                    if (fROB_probeDestReqd_IN) begin
                        push_d      = 1'b1;
                        push_data_d = fROB_probePhysDest_IN;
                    end
                    ptr_d   = ptr_q - ROB_ADDRWIDTH'(1);
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        // Capture the RRAT on the edge that enters OVERWRITE.
                        snap_d  = fRRAT_data_IN;
                        state_d = S_OVERWRITE;
                    end
                end
            end

            S_OVERWRITE: state_d = S_DONE;

            S_DONE:      state_d = S_IDLE;

            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            snap_q      <= snap_d;
        end
    end

    // All outputs are decoded from registers only.
    assign tROB_probeIdx_OUT        = ptr_q;
    assign tFreeL_pushReq_OUT       = push_q;
    assign tFreeL_pushData_OUT      = push_data_q;
    assign tRenRatOverwrite_OUT     = (state_q == S_OVERWRITE);
    assign tRenRatOverwriteData_OUT = snap_q;
    assign tFrontEnd_freeze_OUT     = (state_q != S_IDLE);
    assign tROB_flushDone_OUT       = (state_q == S_DONE);

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Directed testbench for rename_recovery_ctrl. Cycle 0 is the cycle in which
// fROB_flushReq_IN is high; outputs are sampled 1ns after each rising edge.
module tb_rename_recovery_ctrl;

    localparam int PW   = 6;
    localparam int RW   = 6;
    localparam int WW   = 6;
    localparam int RD   = 32;
    localparam int SW   = WW * RD;
    localparam int MAXC = 120;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_req;
    logic [RW-1:0] flush_head;
    logic [RW-1:0] cur_tail;
    logic          rob_full;
    logic [RW-1:0] probe_idx;
    logic          probe_req;
    logic [PW-1:0] probe_dest;
    logic          commit;
    logic [PW-1:0] commit_data;
    logic          freel_full;
    logic          push;
    logic [PW-1:0] push_data;
    logic [SW-1:0] rrat;
    logic          ow;
    logic [SW-1:0] ow_data;
    logic          freeze;
    logic          done;

    always #5 clk = ~clk;

    // Small ROB model answering the combinational probe.
    logic          rob_req  [0:63];
    logic [PW-1:0] rob_dest [0:63];
    assign probe_req  = rob_req[probe_idx];
    assign probe_dest = rob_dest[probe_idx];

    // Per-cycle stimulus tables and recorded traces.
    logic          cm_tab  [0:MAXC];
    logic [PW-1:0] cmd_tab [0:MAXC];
    logic          fl_tab  [0:MAXC];
    logic          fr_tab  [0:MAXC];
    logic          tr_frz  [0:MAXC];
    logic          tr_push [0:MAXC];
    logic [PW-1:0] tr_pd   [0:MAXC];
    logic [RW-1:0] tr_pi   [0:MAXC];
    logic          tr_ow   [0:MAXC];
    logic          tr_done [0:MAXC];
    logic [SW-1:0] tr_owd  [0:MAXC];
    int            end_cyc;

    int tests = 0;
    int fails = 0;

    rename_recovery_ctrl #(
        .PHYSREGS_DEPTH(PW), .ROB_ADDRWIDTH(RW), .RENRAT_WIDTH(WW), .RENRAT_DEPTH(RD)
    ) dut (
        .CLK                      (clk),
        .RESET                    (rst),
        .fROB_flushReq_IN         (flush_req),
        .fROB_flushHead_IN        (flush_head),
        .fROB_curTail_IN          (cur_tail),
        .fROB_full_IN             (rob_full),
        .tROB_probeIdx_OUT        (probe_idx),
        .fROB_probeDestReqd_IN    (probe_req),
        .fROB_probePhysDest_IN    (probe_dest),
        .fCommit_freeReq_IN       (commit),
        .fCommit_freeData_IN      (commit_data),
        .fFreeL_full_IN           (freel_full),
        .tFreeL_pushReq_OUT       (push),
        .tFreeL_pushData_OUT      (push_data),
        .fRRAT_data_IN            (rrat),
        .tRenRatOverwrite_OUT     (ow),
        .tRenRatOverwriteData_OUT (ow_data),
        .tFrontEnd_freeze_OUT     (freeze),
        .tROB_flushDone_OUT       (done)
    );

    task automatic clear_tabs();
        for (int i = 0; i <= MAXC; i++) begin
            cm_tab[i] = 1'b0; cmd_tab[i] = '0; fl_tab[i] = 1'b0; fr_tab[i] = 1'b0;
            tr_frz[i] = 1'b0; tr_push[i] = 1'b0; tr_pd[i] = '0; tr_pi[i] = '0;
            tr_ow[i] = 1'b0; tr_done[i] = 1'b0; tr_owd[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            rob_req[i] = 1'b0; rob_dest[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        flush_req = 1'b0; flush_head = '0; cur_tail = '0; rob_full = 1'b0;
        commit = 1'b0; commit_data = '0; freel_full = 1'b0;
    endtask

    // Raise a flush in cycle 0, then record outputs each cycle until freeze
    // drops. A second flush from fr_tab uses an unrelated head/tail pair.
    task automatic do_flush(input logic [RW-1:0] head, input logic [RW-1:0] tail,
                            input logic full);
        @(posedge clk); #1;
        flush_req = 1'b1; flush_head = head; cur_tail = tail; rob_full = full;
        commit = cm_tab[0]; commit_data = cmd_tab[0]; freel_full = fl_tab[0];
        end_cyc = 0;
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk); #1;
            tr_frz[c] = freeze; tr_push[c] = push; tr_pd[c] = push_data;
            tr_pi[c] = probe_idx; tr_ow[c] = ow; tr_done[c] = done; tr_owd[c] = ow_data;
            flush_req = fr_tab[c];
            if (fr_tab[c]) begin flush_head = 6'd0; cur_tail = 6'd20; rob_full = 1'b0; end
            commit = cm_tab[c]; commit_data = cmd_tab[c]; freel_full = fl_tab[c];
            if (!freeze) begin end_cyc = c; break; end
        end
        idle_inputs();
        tests++;
        if (end_cyc == 0) begin
            fails++;
            $display("FAIL timeout: freeze still high after %0d cycles (required low)", MAXC);
        end
    endtask

    task automatic test_reset();
        idle_inputs(); rrat = '0; rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        tests++; if (freeze !== 1'b0)  begin fails++; $display("FAIL reset_freeze: got %b want 0", freeze); end
        tests++; if (push !== 1'b0)    begin fails++; $display("FAIL reset_push: got %b want 0", push); end
        tests++; if (push_data !== '0) begin fails++; $display("FAIL reset_pushdata: got %0d want 0", push_data); end
        tests++; if (ow !== 1'b0)      begin fails++; $display("FAIL reset_ow: got %b want 0", ow); end
        tests++; if (ow_data !== '0)   begin fails++; $display("FAIL reset_owdata: got %h want 0", ow_data); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (probe_idx !== '0) begin fails++; $display("FAIL reset_probe: got %0d want 0", probe_idx); end
        rst = 1'b0;
    endtask

    // head=4 tail=7, probes 6/5/4 -> pushes 40@2, 33@4, overwrite@4, done@5.
    task automatic check_basic_schedule(input string nm);
        logic [RW-1:0] exp_pi [1:3];
        exp_pi[1] = 6'd6; exp_pi[2] = 6'd5; exp_pi[3] = 6'd4;
        tests++; if (end_cyc !== 6) begin fails++; $display("FAIL %s_end: freeze low at %0d want 6", nm, end_cyc); end
        for (int c = 1; c <= 6; c++) begin
            tests++; if (tr_frz[c] !== (c <= 5)) begin fails++; $display("FAIL %s_freeze@%0d: got %b want %b", nm, c, tr_frz[c], c <= 5); end
            tests++; if (tr_push[c] !== (c == 2 || c == 4)) begin fails++; $display("FAIL %s_push@%0d: got %b want %b", nm, c, tr_push[c], c == 2 || c == 4); end
            tests++; if (tr_ow[c] !== (c == 4)) begin fails++; $display("FAIL %s_ow@%0d: got %b want %b", nm, c, tr_ow[c], c == 4); end
            tests++; if (tr_done[c] !== (c == 5)) begin fails++; $display("FAIL %s_done@%0d: got %b want %b", nm, c, tr_done[c], c == 5); end
        end
        for (int c = 1; c <= 3; c++) begin
            tests++; if (tr_pi[c] !== exp_pi[c]) begin fails++; $display("FAIL %s_probe@%0d: got %0d want %0d", nm, c, tr_pi[c], exp_pi[c]); end
        end
        tests++; if (tr_pd[2] !== 6'd40) begin fails++; $display("FAIL %s_pushdata@2: got %0d want 40", nm, tr_pd[2]); end
        tests++; if (tr_pd[4] !== 6'd33) begin fails++; $display("FAIL %s_pushdata@4: got %0d want 33", nm, tr_pd[4]); end
    endtask

    task automatic setup_basic_rob();
        rob_req[6] = 1'b1; rob_dest[6] = 6'd40;
        rob_req[5] = 1'b0; rob_dest[5] = 6'd17;
        rob_req[4] = 1'b1; rob_dest[4] = 6'd33;
    endtask

    task automatic test_basic_walk();
        clear_tabs(); setup_basic_rob();
        do_flush(6'd4, 6'd7, 1'b0);
        check_basic_schedule("basic");
    endtask

    task automatic test_wrap();
        logic [RW-1:0] exp_pi [1:3];
        exp_pi[1] = 6'd0; exp_pi[2] = 6'd63; exp_pi[3] = 6'd62;
        clear_tabs();
        do_flush(6'd62, 6'd1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tests++; if (tr_pi[c] !== exp_pi[c]) begin fails++; $display("FAIL wrap_probe@%0d: got %0d want %0d", c, tr_pi[c], exp_pi[c]); end
        end
        tests++; if (tr_ow[4] !== 1'b1)   begin fails++; $display("FAIL wrap_ow@4: got %b want 1", tr_ow[4]); end
        tests++; if (tr_done[5] !== 1'b1) begin fails++; $display("FAIL wrap_done@5: got %b want 1", tr_done[5]); end
        tests++; if (end_cyc !== 6) begin fails++; $display("FAIL wrap_end: freeze low at %0d want 6", end_cyc); end
    endtask

    task automatic test_full_rob();
        logic [RW-1:0] e;
        logic [RW-1:0] ep;
        clear_tabs();
        for (int i = 0; i < 64; i++) begin rob_req[i] = 1'b1; rob_dest[i] = 6'(i); end
        do_flush(6'd10, 6'd10, 1'b1);
        tests++; if (end_cyc !== 67) begin fails++; $display("FAIL full_end: freeze low at %0d want 67", end_cyc); end
        for (int c = 1; c <= 66; c++) begin
            e  = 6'(9 - (c - 1));
            ep = 6'(9 - (c - 2));
            if (c <= 64) begin
                tests++; if (tr_pi[c] !== e) begin fails++; $display("FAIL full_probe@%0d: got %0d want %0d", c, tr_pi[c], e); end
            end
            tests++; if (tr_push[c] !== (c >= 2 && c <= 65)) begin fails++; $display("FAIL full_push@%0d: got %b want %b", c, tr_push[c], c >= 2 && c <= 65); end
            if (c >= 2 && c <= 65) begin
                tests++; if (tr_pd[c] !== ep) begin fails++; $display("FAIL full_pushdata@%0d: got %0d want %0d", c, tr_pd[c], ep); end
            end
            tests++; if (tr_ow[c] !== (c == 65)) begin fails++; $display("FAIL full_ow@%0d: got %b want %b", c, tr_ow[c], c == 65); end
            tests++; if (tr_done[c] !== (c == 66)) begin fails++; $display("FAIL full_done@%0d: got %b want %b", c, tr_done[c], c == 66); end
        end
        tests++; if (tr_pi[64] !== 6'd10) begin fails++; $display("FAIL full_lastprobe: got %0d want 10", tr_pi[64]); end

        // Same head/tail without the full flag squashes nothing.
        clear_tabs();
        for (int i = 0; i < 64; i++) begin rob_req[i] = 1'b1; rob_dest[i] = 6'(i); end
        do_flush(6'd10, 6'd10, 1'b0);
        tests++; if (tr_ow[1] !== 1'b1)   begin fails++; $display("FAIL empty_ow@1: got %b want 1", tr_ow[1]); end
        tests++; if (tr_done[2] !== 1'b1) begin fails++; $display("FAIL empty_done@2: got %b want 1", tr_done[2]); end
        tests++; if (tr_ow[2] !== 1'b0)   begin fails++; $display("FAIL empty_ow@2: got %b want 0", tr_ow[2]); end
        tests++; if (end_cyc !== 3) begin fails++; $display("FAIL empty_end: freeze low at %0d want 3", end_cyc); end
        for (int c = 1; c <= 3; c++) begin
            tests++; if (tr_push[c] !== 1'b0) begin fails++; $display("FAIL empty_push@%0d: got %b want 0", c, tr_push[c]); end
        end
    endtask

    // Commit free of 12 in cycle 2, free list full in cycles 4-5.
    task automatic test_contention();
        logic [RW-1:0] exp_pi [1:6];
        exp_pi[1] = 6'd6; exp_pi[2] = 6'd5; exp_pi[3] = 6'd5;
        exp_pi[4] = 6'd4; exp_pi[5] = 6'd4; exp_pi[6] = 6'd4;
        clear_tabs(); setup_basic_rob();
        cm_tab[2] = 1'b1; cmd_tab[2] = 6'd12;
        fl_tab[4] = 1'b1; fl_tab[5] = 1'b1;
        do_flush(6'd4, 6'd7, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tests++; if (tr_pi[c] !== exp_pi[c]) begin fails++; $display("FAIL cont_probe@%0d: got %0d want %0d", c, tr_pi[c], exp_pi[c]); end
        end
        for (int c = 1; c <= 9; c++) begin
            tests++; if (tr_push[c] !== (c == 2 || c == 3 || c == 7)) begin fails++; $display("FAIL cont_push@%0d: got %b want %b", c, tr_push[c], c == 2 || c == 3 || c == 7); end
            tests++; if (tr_ow[c] !== (c == 7)) begin fails++; $display("FAIL cont_ow@%0d: got %b want %b", c, tr_ow[c], c == 7); end
            tests++; if (tr_done[c] !== (c == 8)) begin fails++; $display("FAIL cont_done@%0d: got %b want %b", c, tr_done[c], c == 8); end
        end
        tests++; if (tr_pd[2] !== 6'd40) begin fails++; $display("FAIL cont_pushdata@2: got %0d want 40", tr_pd[2]); end
        tests++; if (tr_pd[3] !== 6'd12) begin fails++; $display("FAIL cont_pushdata@3: got %0d want 12", tr_pd[3]); end
        tests++; if (tr_pd[7] !== 6'd33) begin fails++; $display("FAIL cont_pushdata@7: got %0d want 33", tr_pd[7]); end
        tests++; if (end_cyc !== 9) begin fails++; $display("FAIL cont_end: freeze low at %0d want 9", end_cyc); end
    endtask

    task automatic test_snapshot();
        logic [SW-1:0] snap;
        for (int i = 0; i < RD; i++) snap[i*WW +: WW] = 6'(i + 3);
        snap[35:30] = 6'h2A;
        clear_tabs(); setup_basic_rob();
        rrat = snap;
        fr_tab[2] = 1'b1;
        do_flush(6'd4, 6'd7, 1'b0);
        check_basic_schedule("snap");
        tests++; if (tr_owd[4][35:30] !== 6'h2A) begin fails++; $display("FAIL snap_entry5: got %h want 2a", tr_owd[4][35:30]); end
        tests++; if (tr_owd[4] !== snap) begin fails++; $display("FAIL snap_full: got %h want %h", tr_owd[4], snap); end
        rrat = ~snap;
        repeat (3) @(posedge clk); #1;
        tests++; if (ow_data !== snap) begin fails++; $display("FAIL snap_hold: got %h want %h", ow_data, snap); end
        tests++; if (freeze !== 1'b0) begin fails++; $display("FAIL snap_idle_freeze: got %b want 0", freeze); end
    endtask

    task automatic test_reset_mid_walk();
        clear_tabs(); setup_basic_rob();
        @(posedge clk); #1;
        flush_req = 1'b1; flush_head = 6'd4; cur_tail = 6'd7;
        @(posedge clk); #1;
        flush_req = 1'b0;
        tests++; if (probe_idx !== 6'd6) begin fails++; $display("FAIL rmid_probe@1: got %0d want 6", probe_idx); end
        @(posedge clk); #1;
        tests++; if (push !== 1'b1 || push_data !== 6'd40) begin fails++; $display("FAIL rmid_push@2: got %b/%0d want 1/40", push, push_data); end
        rst = 1'b1; commit = 1'b1; commit_data = 6'd9;
        @(posedge clk); #1;
        tests++; if (freeze !== 1'b0)  begin fails++; $display("FAIL rmid_freeze: got %b want 0", freeze); end
        tests++; if (push !== 1'b0)    begin fails++; $display("FAIL rmid_push: got %b want 0", push); end
        tests++; if (push_data !== '0) begin fails++; $display("FAIL rmid_pushdata: got %0d want 0", push_data); end
        tests++; if (ow !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rmid_ow_done: got %b/%b want 0/0", ow, done); end
        tests++; if (ow_data !== '0)   begin fails++; $display("FAIL rmid_owdata: got %h want 0", ow_data); end
        tests++; if (probe_idx !== '0) begin fails++; $display("FAIL rmid_probe: got %0d want 0", probe_idx); end
        rst = 1'b0; commit = 1'b0; commit_data = '0;
        @(posedge clk); #1;
        tests++; if (freeze !== 1'b0) begin fails++; $display("FAIL rmid_idle: got %b want 0", freeze); end
        do_flush(6'd4, 6'd7, 1'b0);
        check_basic_schedule("rmid_fresh");
    endtask

    initial begin
        clear_tabs();
        idle_inputs();
        rrat = '0;
        rst  = 1'b1;
        test_reset();
        test_basic_walk();
        test_wrap();
        test_full_rob();
        test_contention();
        test_snapshot();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // The overwrite strobe and completion pulse must never coincide.
    always @(negedge clk) begin
        if (!rst && ow && done) begin
            tests++; fails++;
            $display("FAIL ow_done_overlap: got ow=1 done=1 want not both");
        end
    end

endmodule
